// File: rtl/ir_sensor_emulator_pkg.sv
// ir_pkg: shared types and constants for the IR sensor emulator.
//   - ir_state_t    : emulator FSM state encoding
//   - IR_*_DEF      : default timing parameters
//   - IR_CNT_W      : width of internal counters and the measurement counter
//   - IR_FE_PERIOD  : measurement period of the IR front-end, in clk cycles
package ir_pkg;

    typedef enum logic [1:0] {
        IR_IDLE   = 2'd0,
        IR_CHARGE = 2'd1,
        IR_DECAY  = 2'd2,
        IR_DONE   = 2'd3
    } ir_state_t;

    localparam int IR_MIN_CHARGE_DEF      = 65;
    localparam int IR_CYCLES_PER_UNIT_DEF = 8;
    localparam int IR_CNT_W               = 16;
    localparam int IR_FE_PERIOD           = 32750;

endpackage

// File: rtl/ir_sensor_emulator_if.sv
// ir_sensor_emulator_if: sensor-line bundle between the IR front-end side
// (master) and the emulator (slave).
//   charge_i, dist_we_i, dist_i                : master -> slave
//   ir_o, ir_oe, busy, meas_done, short_err,
//   abort, meas_count                          : slave -> master
interface ir_sensor_emulator_if #(
    parameter int CNT_W = ir_pkg::IR_CNT_W
);
    logic             charge_i;
    logic             dist_we_i;
    logic [7:0]       dist_i;
    logic             ir_o;
    logic             ir_oe;
    logic             busy;
    logic             meas_done;
    logic             short_err;
    logic             abort;
    logic [CNT_W-1:0] meas_count;

    modport master (
        output charge_i, dist_we_i, dist_i,
        input  ir_o, ir_oe, busy, meas_done, short_err, abort, meas_count
    );

    modport slave (
        input  charge_i, dist_we_i, dist_i,
        output ir_o, ir_oe, busy, meas_done, short_err, abort, meas_count
    );
endinterface

// File: rtl/ir_sensor_emulator_pulse_timer.sv
// ir_pulse_timer: loadable down-counter used to time the decay pulse.
//   clk, rst    : clock, synchronous active-high reset
//   i_load      : load i_load_val (has priority over i_en)
//   i_load_val  : value to load
//   i_en        : decrement by one, holding at zero
//   o_last      : count is 1, i.e. the current cycle is the final one
module ir_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/ir_sensor_emulator.sv
// ir_sensor_emulator: answers the host's charge drive on the sensor line with
// a high pulse whose width is dist_q * CYCLES_PER_UNIT clk cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ir_sensor_emulator_if.slave (charge input, distance write,
//              emulated line level/enable, status pulses, measurement count)
//
// state  | meaning
// IDLE   | line released, waiting for host charge drive
// CHARGE | host is driving; counting charge length
// DECAY  | emulator drives the line high for W cycles
// DONE   | one cycle, line driven low, measurement reported
module ir_sensor_emulator
    import ir_pkg::*;
#(
    parameter int MIN_CHARGE      = IR_MIN_CHARGE_DEF,
    parameter int CYCLES_PER_UNIT = IR_CYCLES_PER_UNIT_DEF,
    parameter int CNT_W           = IR_CNT_W
) (
    input logic                 clk,
    input logic                 rst,
    ir_sensor_emulator_if.slave bus
);

    localparam logic [CNT_W-1:0] MIN_CHARGE_C = CNT_W'(MIN_CHARGE);
    localparam logic [CNT_W-1:0] CPU_C        = CNT_W'(CYCLES_PER_UNIT);

    ir_state_t        r_state;
    logic [7:0]       r_dist_q;
    logic [CNT_W-1:0] r_charge_cnt;
    logic [CNT_W-1:0] r_meas_count;
    logic             r_ir_o;
    logic             r_ir_oe;
    logic             r_busy;
    logic             r_meas_done;
    logic             r_short_err;
    logic             r_abort;

    logic [CNT_W-1:0] w_width;
    logic             w_charge_ok;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic             w_last;

    assign w_width     = CNT_W'(r_dist_q) * CPU_C;
    assign w_charge_ok = (r_charge_cnt >= MIN_CHARGE_C);
    // The timer samples dist_q only here, so later writes never disturb a
    // pulse already in flight.
    assign w_tmr_load  = (r_state == IR_CHARGE) && !bus.charge_i && w_charge_ok
                         && (w_width != '0);
    assign w_tmr_en    = (r_state == IR_DECAY);

    ir_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_width),
        .i_en       (w_tmr_en),
        .o_last     (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IR_IDLE;
            r_dist_q     <= '0;
            r_charge_cnt <= '0;
            r_meas_count <= '0;
            r_ir_o       <= 1'b0;
            r_ir_oe      <= 1'b0;
            r_busy       <= 1'b0;
            r_meas_done  <= 1'b0;
            r_short_err  <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_meas_done <= 1'b0;
            r_short_err <= 1'b0;
            r_abort     <= 1'b0;

            if (bus.dist_we_i) begin
                r_dist_q <= bus.dist_i;
            end

            case (r_state)
                IR_IDLE: begin
                    r_ir_o  <= 1'b0;
                    r_ir_oe <= 1'b0;
                    if (bus.charge_i) begin
                        r_state      <= IR_CHARGE;
                        r_charge_cnt <= CNT_W'(1);
                        r_busy       <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                IR_CHARGE: begin
                    if (bus.charge_i) begin
                        if (r_charge_cnt != '1) begin
                            r_charge_cnt <= r_charge_cnt + 1'b1;
                        end
                    end else if (w_charge_ok) begin
                        if (w_width != '0) begin
                            r_state <= IR_DECAY;
                            r_ir_o  <= 1'b1;
                            r_ir_oe <= 1'b1;
                        end else begin
                            // Zero distance: skip the pulse, report at once.
                            r_state      <= IR_DONE;
                            r_ir_o       <= 1'b0;
                            r_ir_oe      <= 1'b1;
                            r_meas_done  <= 1'b1;
                            r_meas_count <= r_meas_count + 1'b1;
                        end
                    end else begin
                        r_state     <= IR_IDLE;
                        r_short_err <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end

                IR_DECAY: begin
                    // Host drive wins over the final pulse cycle.
                    if (bus.charge_i) begin
                        r_state      <= IR_CHARGE;
                        r_charge_cnt <= CNT_W'(1);
                        r_abort      <= 1'b1;
                        r_ir_o       <= 1'b0;
                        r_ir_oe      <= 1'b0;
                    end else if (w_last) begin
                        r_state      <= IR_DONE;
                        r_ir_o       <= 1'b0;
                        r_ir_oe      <= 1'b1;
                        r_meas_done  <= 1'b1;
                        r_meas_count <= r_meas_count + 1'b1;
                    end
                end

                IR_DONE: begin
                    r_ir_o  <= 1'b0;
                    r_ir_oe <= 1'b0;
                    if (bus.charge_i) begin
                        r_state      <= IR_CHARGE;
                        r_charge_cnt <= CNT_W'(1);
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= IR_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IR_IDLE;
                    r_ir_o  <= 1'b0;
                    r_ir_oe <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ir_o       = r_ir_o;
    assign bus.ir_oe      = r_ir_oe;
    assign bus.busy       = r_busy;
    assign bus.meas_done  = r_meas_done;
    assign bus.short_err  = r_short_err;
    assign bus.abort      = r_abort;
    assign bus.meas_count = r_meas_count;

endmodule

// File: tb/tb_ir_sensor_emulator.sv
// tb_ir_sensor_emulator: self-checking bench for ir_sensor_emulator.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ir_sensor_emulator;

    localparam int MIN_CH = 65;
    localparam int CPU    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ir_sensor_emulator_if #(.CNT_W(16)) bus();

    ir_sensor_emulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    function automatic int exp_width(input int d);
        return d * CPU;
    endfunction

    // Hold charge high for h sampling edges, then release. Counts any cycle
    // in which the emulator enabled its driver while the host was driving.
    task automatic drive_charge(input int h, output int oe_seen);
        oe_seen = 0;
        bus.charge_i = 1'b1;
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            bus.dist_we_i = 1'b0;
            if (bus.ir_oe !== 1'b0) oe_seen++;
        end
        bus.charge_i = 1'b0;
    endtask

    // Observe the response after charge release; k=1 is the cycle after the
    // first edge that sees charge low. Optionally writes dist at cycle wr_k.
    task automatic measure(input int budget, input int wr_k, input int wr_val,
                           output int hi, output int first_hi,
                           output int done_k, output int oe_bad);
        hi = 0; first_hi = -1; done_k = -1; oe_bad = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            bus.dist_we_i = 1'b0;
            if (k == wr_k) begin
                bus.dist_i    = 8'(wr_val);
                bus.dist_we_i = 1'b1;
            end
            if (bus.ir_o === 1'b1) begin
                hi++;
                if (first_hi < 0) first_hi = k;
                if (bus.ir_oe !== 1'b1) oe_bad++;
            end
            if (bus.meas_done === 1'b1) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic set_dist(input int d);
        bus.dist_i    = 8'(d);
        bus.dist_we_i = 1'b1;
        @(negedge clk);
        bus.dist_we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.charge_i  = 1'b0;
        bus.dist_we_i = 1'b0;
        bus.dist_i    = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ir_o, bus.ir_oe, bus.busy, bus.meas_done, bus.short_err, bus.abort} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {bus.ir_o, bus.ir_oe, bus.busy, bus.meas_done, bus.short_err, bus.abort});
        end
        checks++;
        if (bus.meas_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus.meas_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int oe, hi, fh, dk, bad;
        set_dist(10);
        drive_charge(MIN_CH, oe);
        checks++;
        if (oe != 0) begin errors++; $display("FAIL basic_oe_during_charge: got %0d cycles expected 0", oe); end
        measure(3000, 0, 0, hi, fh, dk, bad);
        exp_count++;
        checks++;
        if (hi != 80) begin errors++; $display("FAIL basic_width: got %0d expected 80", hi); end
        checks++;
        if (fh != 1) begin errors++; $display("FAIL basic_first_high: got %0d expected 1", fh); end
        checks++;
        if (dk != 81) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 81", dk); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_oe_in_pulse: got %0d low cycles expected 0", bad); end
        checks++;
        if (bus.meas_count !== 16'(exp_count)) begin
            errors++; $display("FAIL basic_count: got %0d expected %0d", bus.meas_count, exp_count);
        end
        @(negedge clk);
        checks++;
        if ({bus.meas_done, bus.busy, bus.ir_oe} !== 3'b000) begin
            errors++; $display("FAIL basic_after_done: got %b expected 000", {bus.meas_done, bus.busy, bus.ir_oe});
        end
    endtask

    task automatic test_short();
        int oe, hi, fh, dk, bad;
        drive_charge(MIN_CH - 1, oe);
        @(negedge clk);
        checks++;
        if ({bus.short_err, bus.ir_oe, bus.busy} !== 3'b100) begin
            errors++; $display("FAIL short_pulse: got %b expected 100", {bus.short_err, bus.ir_oe, bus.busy});
        end
        @(negedge clk);
        checks++;
        if (bus.short_err !== 1'b0 || bus.meas_count !== 16'(exp_count)) begin
            errors++; $display("FAIL short_after: got err=%b count=%0d expected err=0 count=%0d",
                               bus.short_err, bus.meas_count, exp_count);
        end
        set_dist(1);
        drive_charge(MIN_CH, oe);
        measure(100, 0, 0, hi, fh, dk, bad);
        exp_count++;
        checks++;
        if (hi != 8 || dk != 9) begin
            errors++; $display("FAIL short_then_valid: got width=%0d done=%0d expected 8/9", hi, dk);
        end
    endtask

    task automatic test_zero_max();
        int oe, hi, fh, dk, bad;
        set_dist(0);
        drive_charge(MIN_CH, oe);
        measure(20, 0, 0, hi, fh, dk, bad);
        exp_count++;
        checks++;
        if (hi != 0 || dk != 1) begin
            errors++; $display("FAIL zero_dist: got width=%0d done=%0d expected 0/1", hi, dk);
        end
        checks++;
        if (bus.meas_count !== 16'(exp_count)) begin
            errors++; $display("FAIL zero_count: got %0d expected %0d", bus.meas_count, exp_count);
        end
        set_dist(255);
        drive_charge(MIN_CH, oe);
        measure(2200, 0, 0, hi, fh, dk, bad);
        exp_count++;
        checks++;
        if (hi != 2040 || dk != 2041 || fh != 1) begin
            errors++; $display("FAIL max_dist: got width=%0d done=%0d first=%0d expected 2040/2041/1", hi, dk, fh);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int oe, hi, fh, dk, bad, aborts;
        set_dist(20);
        drive_charge(MIN_CH, oe);
        hi = 0;
        for (int k = 0; k < 300 && hi < 50; k++) begin
            @(negedge clk);
            if (bus.ir_o === 1'b1) hi++;
        end
        bus.charge_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.abort, bus.ir_o, bus.ir_oe, bus.busy, bus.meas_done} !== 5'b10010) begin
            errors++; $display("FAIL abort_pulse: got %b expected 10010",
                               {bus.abort, bus.ir_o, bus.ir_oe, bus.busy, bus.meas_done});
        end
        checks++;
        if (bus.meas_count !== 16'(exp_count)) begin
            errors++; $display("FAIL abort_count: got %0d expected %0d", bus.meas_count, exp_count);
        end
        aborts = 0;
        for (int i = 0; i < MIN_CH - 1; i++) begin
            @(negedge clk);
            if (bus.abort === 1'b1 || bus.ir_oe === 1'b1) aborts++;
        end
        bus.charge_i = 1'b0;
        checks++;
        if (aborts != 0) begin errors++; $display("FAIL abort_hold: got %0d bad cycles expected 0", aborts); end
        measure(400, 0, 0, hi, fh, dk, bad);
        exp_count++;
        checks++;
        if (hi != 160 || dk != 161) begin
            errors++; $display("FAIL abort_recharge: got width=%0d done=%0d expected 160/161", hi, dk);
        end
    endtask

    task automatic test_dist_write();
        int oe, hi, fh, dk, bad;
        set_dist(30);
        drive_charge(MIN_CH, oe);
        measure(400, 10, 5, hi, fh, dk, bad);
        exp_count++;
        checks++;
        if (hi != exp_width(30) || dk != exp_width(30) + 1) begin
            errors++; $display("FAIL write_in_flight: got width=%0d done=%0d expected %0d/%0d",
                               hi, dk, exp_width(30), exp_width(30) + 1);
        end
        drive_charge(MIN_CH, oe);
        measure(400, 0, 0, hi, fh, dk, bad);
        exp_count++;
        checks++;
        if (hi != exp_width(5) || dk != exp_width(5) + 1) begin
            errors++; $display("FAIL write_next: got width=%0d done=%0d expected %0d", hi, dk, exp_width(5));
        end
    endtask

    task automatic test_back_to_back();
        int oe, hi, fh, dk, bad, d;
        set_dist(30);
        drive_charge(MIN_CH, oe);
        hi = 0;
        for (int k = 0; k < 400 && hi < 100; k++) begin
            @(negedge clk);
            if (bus.ir_o === 1'b1) hi++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ir_o, bus.ir_oe, bus.busy} !== 3'b000 || bus.meas_count !== 16'd0) begin
            errors++; $display("FAIL reset_mid: got o/oe/busy=%b count=%0d expected 000/0",
                               {bus.ir_o, bus.ir_oe, bus.busy}, bus.meas_count);
        end
        rst = 1'b0;
        exp_count = 0;
        @(negedge clk);
        d = $urandom_range(1, 40);
        bus.dist_i = 8'(d);
        bus.dist_we_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_charge(MIN_CH + $urandom_range(0, 5), oe);
            measure(400, 0, 0, hi, fh, dk, bad);
            exp_count++;
            checks++;
            if (hi != exp_width(d) || dk != exp_width(d) + 1 || bus.meas_count !== 16'(exp_count)) begin
                errors++; $display("FAIL b2b_%0d: got width=%0d done=%0d count=%0d expected %0d/%0d/%0d",
                                   i, hi, dk, bus.meas_count, exp_width(d), exp_width(d) + 1, exp_count);
            end
            d = $urandom_range(1, 40);
            bus.dist_i = 8'(d);
            bus.dist_we_i = 1'b1;
        end
        bus.dist_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int oe, hi, fh, dk, bad, d, h;
        for (int it = 0; it < 12; it++) begin
            d = $urandom_range(0, 63);
            h = $urandom_range(MIN_CH - 5, MIN_CH + 7);
            set_dist(d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            drive_charge(h, oe);
            if (h >= MIN_CH) begin
                measure(700, 0, 0, hi, fh, dk, bad);
                exp_count++;
                checks++;
                if (hi != exp_width(d) || dk != exp_width(d) + 1 || bad != 0 ||
                    bus.meas_count !== 16'(exp_count)) begin
                    errors++; $display("FAIL rand_%0d d=%0d h=%0d: got width=%0d done=%0d count=%0d expected %0d/%0d/%0d",
                                       it, d, h, hi, dk, bus.meas_count, exp_width(d), exp_width(d) + 1, exp_count);
                end
            end else begin
                @(negedge clk);
                checks++;
                if (bus.short_err !== 1'b1 || bus.ir_oe !== 1'b0 || bus.meas_count !== 16'(exp_count)) begin
                    errors++; $display("FAIL rand_short_%0d h=%0d: got err=%b oe=%b count=%0d expected 1/0/%0d",
                                       it, h, bus.short_err, bus.ir_oe, bus.meas_count, exp_count);
                end
            end
            checks++;
            if (oe != 0) begin errors++; $display("FAIL rand_contention_%0d: got %0d cycles expected 0", it, oe); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_zero_max();
        test_abort();
        test_dist_write();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ir_sensor_emulator.md
Name: ir_sensor_emulator

Overview:
Emulates the reflectance sensor's RC-decay output so the IR distance front-end can be exercised on hardware and in simulation without a real sensor. The block watches the host's discharge/charge drive on the sensor line. When the drive ends, it returns a high pulse whose width is proportional to a programmed distance. It sits on the sensor-line side of the tristate pad, acting as the responder to the IR measurement front-end.

Parameters:
MIN_CHARGE, 65, minimum consecutive cycles charge_i must be high for a valid charge; 1.3 us at 50 MHz
CYCLES_PER_UNIT, 8, pulse cycles per distance LSB; ≈1/0.1234 so the front-end reads back the programmed distance
CNT_W, 16, width of internal counters and meas_count

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
charge_i  input  1  host drive level on sensor line; 1 = host discharging/charging
dist_we_i  input  1  write strobe for dist_i
dist_i  input  8  distance value to emulate
ir_o  output  1  emulated sensor level
ir_oe  output  1  1 = emulator drives ir_o onto the line
busy  output  1  1 in any state except IDLE
meas_done  output  1  one-cycle pulse at end of each decay pulse
short_err  output  1  one-cycle pulse when a charge is shorter than MIN_CHARGE
abort  output  1  one-cycle pulse when charge_i rises during DECAY
meas_count  output  CNT_W  completed measurements, wraps at 2^CNT_W

Behaviour:
- Clock and reset: rst is synchronous and active-high; clk is the clock. All outputs are registered.
- Reset values:
  - State IDLE; ir_o=0, ir_oe=0, busy=0.
  - meas_done, short_err and abort are 0.
  - meas_count=0.
  - Shadow distance register dist_q=0; charge counter=0; decay counter=0.
- Distance register: when dist_we_i=1, dist_q<=dist_i. This is accepted in any state. dist_q is copied into the active width only on DECAY entry, so a write during DECAY does not affect the pulse in flight.
- Width computation: W = dist_q * CYCLES_PER_UNIT, computed at CNT_W bits. The maximum is 255*8 = 2040, so no overflow occurs at the defaults.
- IDLE:
  - ir_oe=0.
  - On charge_i=1: go to CHARGE with charge_cnt=1.
- CHARGE:
  - ir_oe=0.
  - While charge_i=1, charge_cnt increments and saturates at 2^CNT_W-1.
  - When charge_i=0 is sampled and charge_cnt>=MIN_CHARGE:
    - If W>0: go to DECAY, load dec_cnt=W, set ir_o=1 and ir_oe=1 from the next cycle.
    - If W=0: go to DONE.
  - When charge_i=0 is sampled and charge_cnt<MIN_CHARGE: pulse short_err and return to IDLE. meas_count is unchanged.
- DECAY:
  - ir_o=1 and ir_oe=1 for exactly W consecutive cycles. dec_cnt decrements each cycle.
  - On the last high cycle (dec_cnt==1), go to DONE.
- DONE (1 cycle):
  - ir_o=0, ir_oe=1.
  - meas_done=1 and meas_count increments.
  - Next state is IDLE, or CHARGE if charge_i=1 in this cycle.
- Latency: if charge_i is first sampled 0 at edge N, ir_o is high at edges N+1 through N+W, and meas_done is high at edge N+W+1.
- Simultaneous events:
  - charge_i=1 during DECAY: pulse abort, ir_o=0, ir_oe=0, go to CHARGE with charge_cnt=1. No meas_done and no meas_count increment.
  - charge_i=1 and dec_cnt==1 in the same cycle: abort has priority.
- Reset mid-operation: rst overrides everything, returns all state to reset values, and drops ir_oe immediately on the next edge.
- Bus contention: ir_oe=0 whenever charge_i may be asserted by the host (IDLE and CHARGE), so the emulator never contends with the host.

Decomposition:
- Shared package ir_pkg holds:
  - state enum IDLE/CHARGE/DECAY/DONE, 2-bit
  - IR_MIN_CHARGE_DEF=65 and IR_CYCLES_PER_UNIT_DEF=8
  - IR_CNT_W=16
  - the front-end period constant 32750
- One sub-module is natural: ir_pulse_timer. It is a loadable CNT_W down-counter with load, en and a "last" flag, and is reused for the DECAY width.

Test Plan:
1. Program dist=10 and hold charge_i high for 65 cycles, then low -> ir_o high for exactly 80 cycles, meas_done at cycle 81, meas_count=1.
2. Hold charge_i high for 64 cycles -> short_err pulse and no ir_oe assertion. Then hold it for 65 cycles with dist=1 -> 8-cycle pulse.
3. Program dist=0 with a valid charge -> ir_o never high, meas_done one cycle after charge_i falls. Program dist=255 -> 2040-cycle pulse.
4. Program dist=20, start DECAY, raise charge_i at pulse cycle 50 -> abort pulse, ir_o=0 the next cycle, meas_count unchanged. Release after 65 cycles -> a fresh 160-cycle pulse.
5. Write dist=5 during a dist=30 pulse -> current pulse is 240 cycles, next pulse is 40 cycles.
6. Assert rst at DECAY cycle 100 -> next edge ir_o=0, ir_oe=0, busy=0, meas_count=0. Run 3 back-to-back measurements -> meas_count=3.
